// File: rtl/conv_1d_tile_sched.sv
// Tile scheduler: walks a conv_bram_1d engine over NUM_TILES filter banks, one launch per tile.
// Optional cycle counter port perf_cycles is enabled with `define CONV_SCHED_PERF_EN.
module conv_1d_tile_sched #(
  parameter int DATA_WIDTH      = 8,
  parameter int IMG_D           = 4,
  parameter int FILTER_L        = 3,
  parameter int RESULT_D        = 4,
  parameter int NUM_TILES       = 4,
  parameter int FIL_WIDTH       = DATA_WIDTH * RESULT_D * IMG_D * FILTER_L,
  parameter int TILE_ADDR_WIDTH = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TILE_ADDR_WIDTH-1:0] fil_rdaddr,
  input  logic [FIL_WIDTH-1:0]       fil_rddata,
  output logic [FIL_WIDTH-1:0]       eng_fil,
  output logic                       eng_val_in,
  input  logic                       eng_rdy_in,
  output logic [TILE_ADDR_WIDTH-1:0] tile_idx
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    FINISH
  } state_e;

  localparam logic [TILE_ADDR_WIDTH-1:0] LAST_TILE = TILE_ADDR_WIDTH'(NUM_TILES - 1);

  state_e                       state_q, state_d;
  logic [TILE_ADDR_WIDTH-1:0]   tile_idx_q, tile_idx_d;
  logic [FIL_WIDTH-1:0]         eng_fil_q, eng_fil_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    tile_idx_d = tile_idx_q;
    eng_fil_d  = eng_fil_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          tile_idx_d = '0;
        end
      end
      FETCH:   state_d = LATCH;
      LATCH: begin
        eng_fil_d = fil_rddata;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (eng_rdy_in) state_d = WAIT_LO;
      end
      // Engines may keep rdy high a few cycles after acceptance; only a low level proves the pass began.
      WAIT_LO: begin
        if (!eng_rdy_in) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (eng_rdy_in) begin
          if (tile_idx_q == LAST_TILE) begin
            state_d = FINISH;
          end else begin
            tile_idx_d = tile_idx_q + TILE_ADDR_WIDTH'(1);
            state_d    = FETCH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tile_idx_q <= '0;
      eng_fil_q  <= '0;
    end else begin
      state_q    <= state_d;
      tile_idx_q <= tile_idx_d;
      eng_fil_q  <= eng_fil_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign eng_val_in = (state_q == ISSUE);
  assign tile_idx   = tile_idx_q;
  assign fil_rdaddr = tile_idx_q;
  assign eng_fil    = eng_fil_q;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    if (state_q == IDLE) begin
      if (start) perf_cycles_d = '0;
    end else if (perf_cycles_q != 32'hFFFF_FFFF) begin
      perf_cycles_d = perf_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) perf_cycles_q <= '0;
    else       perf_cycles_q <= perf_cycles_d;
  end

  assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_conv_1d_tile_sched.sv
// Scoreboard bench for conv_1d_tile_sched: tiles expected per layer are queued at start and
// popped by a monitor on every engine handshake; a behavioural engine drives eng_rdy_in.
module tb_conv_1d_tile_sched;

  localparam int DW = 8;
  localparam int ID = 4;
  localparam int FL = 3;
  localparam int RD = 4;
  localparam int NT = 4;
  localparam int FW = DW * RD * ID * FL;
  localparam int AW = (NT > 1) ? $clog2(NT) : 1;
  localparam int TIMEOUT = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] fil_rdaddr;
  logic [FW-1:0] fil_rddata;
  logic [FW-1:0] eng_fil;
  logic          eng_val_in;
  logic          eng_rdy_in;
  logic [AW-1:0] tile_idx;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  conv_1d_tile_sched #(
    .DATA_WIDTH(DW), .IMG_D(ID), .FILTER_L(FL), .RESULT_D(RD), .NUM_TILES(NT)
  ) dut (
`ifdef CONV_SCHED_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .fil_rdaddr(fil_rdaddr), .fil_rddata(fil_rddata), .eng_fil(eng_fil),
    .eng_val_in(eng_val_in), .eng_rdy_in(eng_rdy_in), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Distinct 384-bit bank per tile.
  function automatic logic [FW-1:0] rom_word(input int k);
    logic [31:0] w;
    w = 32'h1234_5670 + 32'(k) * 32'h0101_0101;
    return {12{w}};
  endfunction

  // Filter ROM with one cycle read latency.
  always @(posedge clk) fil_rddata <= rom_word(int'(fil_rdaddr));

  // Engine model: knobs set by the stimulus before each layer.
  int stall_len = 0;
  int hi_extra  = 0;
  int run_len   = 10;

  initial begin
    logic [FW-1:0] f;
    logic [AW-1:0] acc;
    eng_rdy_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (eng_val_in) begin
        acc = tile_idx;
        if (stall_len > 0) begin
          eng_rdy_in = 1'b0;
          f = eng_fil;
          repeat (stall_len) begin
            @(posedge clk); #1;
            check("stall_val_held", eng_val_in, 1);
            check("stall_fil_stable", eng_fil, f);
          end
          eng_rdy_in = 1'b1;
        end
        @(posedge clk); #1;
        repeat (hi_extra) begin
          check("wait_lo_tile_held", tile_idx, acc);
          check("wait_lo_no_val", eng_val_in, 0);
          @(posedge clk); #1;
        end
        eng_rdy_in = 1'b0;
        repeat (run_len) @(posedge clk);
        #1;
        eng_rdy_in = 1'b1;
      end
    end
  end

  // Scoreboard.
  logic [AW-1:0] exp_tile_q[$];
  logic [AW-1:0] exp_t;
  int            exp_done = 0;
  int            got_done = 0;
  bit            after_done = 1'b0;

  always @(negedge clk) begin
    if (!reset && eng_val_in && eng_rdy_in) begin
      if (exp_tile_q.size() == 0) begin
        check("unexpected_handshake", tile_idx, {AW{1'bx}});
      end else begin
        exp_t = exp_tile_q.pop_front();
        check("hs_tile_idx", tile_idx, exp_t);
        check("hs_fil_rdaddr", fil_rdaddr, exp_t);
        check("hs_eng_fil", eng_fil, rom_word(int'(exp_t)));
      end
    end
    if (done) begin
      got_done++;
      check("done_tile_idx", tile_idx, NT - 1);
      after_done = 1'b1;
    end else if (after_done) begin
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      after_done = 1'b0;
    end
  end

  // Launches one layer and waits for done; optionally pulses start again while tile 2 runs.
  task automatic run_layer(input bit pulse_mid);
    int  n;
    int  bc;
    bit  pulsed;
    for (int k = 0; k < NT; k++) exp_tile_q.push_back(AW'(k));
    exp_done++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", busy, 1);
    check("start_tile_idx", tile_idx, 0);
    n = 0; bc = 0; pulsed = 1'b0;
    while (n < TIMEOUT) begin
      if (busy) bc++;
      if (done) break;
      if (pulse_mid && !pulsed && tile_idx == AW'(2)) begin
        start = 1'b1; pulsed = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check("done_timeout", n < TIMEOUT, 1);
    @(negedge clk);
    check("scoreboard_drained", exp_tile_q.size(), 0);
`ifdef CONV_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, bc);
    repeat (3) @(negedge clk);
    check("perf_cycles_hold", perf_cycles, bc);
`else
    check("layer_min_busy", bc >= NT * 5, 1);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_val", eng_val_in, 0);
    check("rst_tile_idx", tile_idx, 0);
    check("rst_eng_fil", eng_fil, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_start", busy, 0);

    // Immediate acceptance, 10-cycle passes.
    stall_len = 0; hi_extra = 0; run_len = 10;
    run_layer(1'b0);

    // Engine keeps rdy low 5 cycles while val is offered.
    stall_len = 5;
    run_layer(1'b0);

    // Engine keeps rdy high 2 cycles after acceptance.
    stall_len = 0; hi_extra = 2;
    run_layer(1'b0);

    // Redundant start during tile 2 must be ignored.
    hi_extra = 0;
    run_layer(1'b1);

    // Abort during WAIT_HI of tile 1.
    for (int k = 0; k < NT; k++) exp_tile_q.push_back(AW'(k));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(tile_idx == AW'(1) && !eng_rdy_in) && n < TIMEOUT) begin
      @(negedge clk); n++;
    end
    check("reach_tile1_timeout", n < TIMEOUT, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_val", eng_val_in, 0);
    check("abort_tile_idx", tile_idx, 0);
    check("abort_eng_fil", eng_fil, 0);
    check("abort_done", done, 0);
    check("abort_remaining", exp_tile_q.size(), NT - 2);
    exp_tile_q.delete();
    reset = 1'b0;
    n = 0;
    while (!eng_rdy_in && n < TIMEOUT) begin
      @(negedge clk); n++;
    end
    check("engine_idle_timeout", n < TIMEOUT, 1);
    run_layer(1'b0);

    repeat (4) @(negedge clk);
    check("done_count", got_done, exp_done);
    check("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
